ms_interval_timer: RTL and testbench
====================================

# ms_interval_timer

Millisecond interval timer that consumes the divided square wave produced by the 1 ms clock divider and turns it into a CPU-visible countdown timer with interrupt. The divider output is treated as an asynchronous input: it is synchronized, and its rising edges are converted to single-cycle ticks. The ticks decrement a loadable counter that runs in one-shot or auto-reload mode. The block sits beside the CPU's peripheral registers and drives a sticky interrupt line with an acknowledge input.

## Interface
- CNT_W, 16, width of the countdown counter and load value
- SYNC_STAGES, 2, flops in the input synchronizer (minimum 2)

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- clk_1ms_in  in  1  divider square wave (period 1 ms); asynchronous to clk; rising edge = one tick
- load  in  1  one-cycle strobe: count and reload register <= load_val
- load_val  in  CNT_W  value captured on load
- start  in  1  one-cycle strobe: begin or resume counting
- stop  in  1  one-cycle strobe: halt counting, hold count
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled at expiry
- irq_ack  in  1  one-cycle strobe: clears irq and ovf
- count  out  CNT_W  current remaining ticks
- running  out  1  high in RUN state
- irq  out  1  sticky expiry interrupt
- ovf  out  1  sticky: an expiry occurred while irq was already set
- tick_1ms  out  1  registered one-cycle pulse per rising edge of clk_1ms_in

## Operation
- **Reset values:** count=0, reload=0, running=0, irq=0, ovf=0, tick_1ms=0. State is IDLE. All synchronizer and edge flops are cleared.
- **Input path:**
  - SYNC_STAGES-flop synchronizer, then one edge-detect flop.
  - tick_1ms <= sync_out & ~prev.
  - Ticks are suppressed for the first SYNC_STAGES+1 cycles after reset release, so an input already high at reset does not produce a spurious tick.
- **States:** IDLE, RUN, EXPIRED.
- **Command priority within a cycle:** load > stop > start > tick. A lower-priority event in the same cycle is dropped.
- **load (any state):** count and reload <= load_val; state -> IDLE. irq and ovf are unchanged.
- **stop:** RUN -> IDLE with count held. It is ignored in IDLE and EXPIRED.
- **start:**
  - IDLE with count != 0 -> RUN.
  - IDLE with count == 0 -> ignored.
  - EXPIRED with reload != 0 -> count <= reload, state -> RUN.
  - EXPIRED with reload == 0 -> ignored.
  - Ignored in RUN.
- **RUN on tick, count > 1:** count <= count-1.
- **RUN on tick, count == 1 (expiry):**
  - irq <= 1.
  - If irq was already 1, ovf <= 1.
  - If mode == 1, count <= reload and the state stays RUN.
  - If mode == 0, count <= 0 and state -> EXPIRED.
- **Ticks outside RUN:** no effect on count. tick_1ms still pulses.
- **irq_ack:** clears irq and ovf. If an expiry occurs in the same cycle, irq=1 is set and ovf stays 0, because the prior irq is considered acknowledged.
- **Arithmetic:** count never wraps. A decrement from 0 cannot occur because RUN always holds count >= 1.
- **running:** equals (state == RUN), registered.
- **Asynchronous reset mid-operation:** returns everything to reset values immediately. No expiry is reported.

## Timing
- Edge E0 is the first clk edge that samples clk_1ms_in high.
  - sync_out rises at E(SYNC_STAGES-1).
  - tick_1ms is high for exactly one cycle after E(SYNC_STAGES).
  - count / irq update at E(SYNC_STAGES+1). With defaults this is 3 cycles from E0.
- **Command response:** load, start, stop and irq_ack take effect on the clock edge that samples them. Outputs are visible the following cycle.
- **Tick rate:** at most one tick per clk_1ms_in period. A high or low level of any length produces exactly one tick per rising edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Basic countdown:** reset; load 5, start, mode=0; drive 5 rising edges -> count steps 4,3,2,1,0; irq rises with count=0; running=0; state EXPIRED; each edge gives exactly one tick_1ms, SYNC_STAGES cycles after sampling.
- **Auto-reload and overflow:** load 3, mode=1, start; 6 edges with no irq_ack -> count 2,1,3,2,1,3; irq=1 after the 3rd edge; ovf=1 after the 6th edge; irq_ack -> both 0; running stays 1.
- **Stop and resume:** load 10, start, 4 edges -> count 6; stop; 3 edges -> count stays 6; start; 6 edges -> expiry.
- **Priority:** load 7 asserted in the same cycle as an internal tick while RUN with count=2 -> count=7, state IDLE, no irq. irq_ack in the same cycle as an expiry with irq already 1 -> irq=1, ovf=0.
- **Reset behaviour:** hold clk_1ms_in high through reset release -> no tick_1ms. Assert rst mid-count (count=4) -> all outputs 0 in the same cycle.
- **Edge cases:** start with count=0 -> running stays 0. In EXPIRED, start with reload=5 -> count=5 and RUN.

Source files
------------

// File: rtl/ms_interval_timer.sv
// Millisecond countdown timer: synchronizes the 1 ms divider square wave, turns its rising
// edges into ticks and counts them down in one-shot or auto-reload mode with a sticky irq.
module ms_interval_timer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1ms_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             irq,
  output logic             ovf,
  output logic             tick_1ms
);

  localparam int unsigned BlankW = $clog2(SYNC_STAGES + 2);
  localparam logic [BlankW-1:0] BlankMax = BlankW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [BlankW-1:0]      blank_q;
  logic                   tick_q, tick_d;
  logic                   sync_out;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       reload_q, reload_d;
  logic                   irq_q, irq_d;
  logic                   ovf_q, ovf_d;
  logic                   running_q;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Blanking keeps an input that is already high at reset release from looking like an edge.
  assign tick_d   = sync_out & ~edge_q & (blank_q == BlankMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      blank_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_1ms_in};
      edge_q  <= sync_out;
      tick_q  <= tick_d;
      if (blank_q != BlankMax) begin
        blank_q <= blank_q + BlankW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    irq_d    = irq_q & ~irq_ack;
    ovf_d    = ovf_q & ~irq_ack;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = StIdle;
    end else if (stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
      end
    end else if (start) begin
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (reload_q != '0) begin
            count_d = reload_q;
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end else if (tick_q && (state_q == StRun)) begin
      if (count_q == CNT_W'(1)) begin
        irq_d = 1'b1;
        // An acknowledge in the same cycle retires the earlier irq, so no overflow.
        if (irq_q && !irq_ack) begin
          ovf_d = 1'b1;
        end
        if (mode) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = StExpired;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      irq_q     <= irq_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == StRun);
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign irq      = irq_q;
  assign ovf      = ovf_q;
  assign tick_1ms = tick_q;

endmodule

// File: tb/tb_ms_interval_timer.sv
// Self-checking bench for ms_interval_timer: directed scenarios plus randomized stimulus,
// all compared every cycle against a behavioural model of the timer.
module tb_ms_interval_timer;

  localparam int unsigned CntW = 16;
  localparam int unsigned Sync = 2;
  localparam int Idle = 0;
  localparam int Run = 1;
  localparam int Expired = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_1ms_in;
  logic            load;
  logic [CntW-1:0] load_val;
  logic            start;
  logic            stop;
  logic            mode;
  logic            irq_ack;
  logic [CntW-1:0] count;
  logic            running;
  logic            irq;
  logic            ovf;
  logic            tick_1ms;

  always #5 clk = ~clk;

  ms_interval_timer #(
    .CNT_W      (CntW),
    .SYNC_STAGES(Sync)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clk_1ms_in(clk_1ms_in),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .irq_ack   (irq_ack),
    .count     (count),
    .running   (running),
    .irq       (irq),
    .ovf       (ovf),
    .tick_1ms  (tick_1ms)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer state plus a history of sampled input levels.
  int          m_state;
  int unsigned m_count;
  int unsigned m_reload;
  bit          m_irq;
  bit          m_ovf;
  bit          m_tick;
  int          n_edges;
  bit          hist[$];

  function automatic void model_reset();
    m_state  = Idle;
    m_count  = 0;
    m_reload = 0;
    m_irq    = 0;
    m_ovf    = 0;
    m_tick   = 0;
    n_edges  = 0;
    hist.delete();
    for (int i = 0; i < Sync + 2; i++) hist.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    bit tick_used = m_tick;
    bit irq_was   = m_irq;
    bit dropped;
    hist.push_front(clk_1ms_in);
    dropped = hist.pop_back();
    // A level sampled high at edge k (low at k-1) shows as a tick after edge k+Sync.
    m_tick = hist[Sync] && !hist[Sync+1] && (n_edges >= Sync + 1);
    if (n_edges < 1000) n_edges++;
    if (irq_ack) begin
      m_irq = 0;
      m_ovf = 0;
    end
    if (load) begin
      m_count  = load_val;
      m_reload = load_val;
      m_state  = Idle;
    end else if (stop) begin
      if (m_state == Run) m_state = Idle;
    end else if (start) begin
      if (m_state == Idle && m_count != 0) m_state = Run;
      else if (m_state == Expired && m_reload != 0) begin
        m_count = m_reload;
        m_state = Run;
      end
    end else if (tick_used && m_state == Run) begin
      if (m_count == 1) begin
        m_irq = 1;
        if (irq_was && !irq_ack) m_ovf = 1;
        if (mode) m_count = m_reload;
        else begin
          m_count = 0;
          m_state = Expired;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("count", 32'(count), m_count);
    check_eq("running", 32'(running), 32'(m_state == Run));
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("tick_1ms", 32'(tick_1ms), 32'(m_tick));
  endtask

  task automatic drive(input logic ld, input logic [CntW-1:0] lv, input logic st,
                       input logic sp, input logic ack, input logic in);
    load       = ld;
    load_val   = lv;
    start      = st;
    stop       = sp;
    irq_ack    = ack;
    clk_1ms_in = in;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int k, input logic in);
    repeat (k) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, in);
  endtask

  task automatic edges(input int k);
    repeat (k) begin
      idle(2, 1'b0);
      idle(2, 1'b1);
    end
    idle(4, 1'b0);
  endtask

  // Drive the input high until the model expects a tick to be pending (bounded).
  task automatic wait_tick();
    for (int i = 0; i < 10 && !m_tick; i++) idle(1, 1'b1);
    check_eq("tick_wait", 32'(tick_1ms), 32'd1);
  endtask

  task automatic async_reset(input logic in_during);
    rst        = 1'b1;
    clk_1ms_in = in_during;
    load       = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    irq_ack    = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_tick", 32'(tick_1ms), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int  hold;
    int  cmd;
    logic cur_in;
    mode     = 1'b0;
    load_val = '0;
    async_reset(1'b1);

    // Input held high through reset release must not tick.
    for (int i = 0; i < 8; i++) begin
      idle(1, 1'b1);
      check_eq("no_spurious_tick", 32'(tick_1ms), 32'd0);
    end

    // Basic one-shot countdown.
    drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(5);
    check_eq("basic_count", 32'(count), 32'd0);
    check_eq("basic_irq", 32'(irq), 32'd1);
    check_eq("basic_running", 32'(running), 32'd0);

    // Auto-reload with overflow, then acknowledge.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    mode = 1'b1;
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(6);
    check_eq("reload_count", 32'(count), 32'd3);
    check_eq("reload_irq", 32'(irq), 32'd1);
    check_eq("reload_ovf", 32'(ovf), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ack_irq", 32'(irq), 32'd0);
    check_eq("ack_ovf", 32'(ovf), 32'd0);
    check_eq("ack_running", 32'(running), 32'd1);

    // Stop and resume.
    mode = 1'b0;
    drive(1'b1, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(4);
    check_eq("stop_pre_count", 32'(count), 32'd6);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    edges(3);
    check_eq("stop_hold_count", 32'(count), 32'd6);
    check_eq("stop_running", 32'(running), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(6);
    check_eq("resume_irq", 32'(irq), 32'd1);
    check_eq("resume_count", 32'(count), 32'd0);

    // Load beats a tick arriving in the same cycle.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(1);
    check_eq("prio_pre_count", 32'(count), 32'd2);
    idle(2, 1'b0);
    wait_tick();
    drive(1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("prio_count", 32'(count), 32'd7);
    check_eq("prio_running", 32'(running), 32'd0);
    check_eq("prio_irq", 32'(irq), 32'd0);
    idle(4, 1'b0);

    // Acknowledge coinciding with an expiry while irq is already set.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(1);
    check_eq("pre_ack_irq", 32'(irq), 32'd1);
    drive(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    wait_tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ackexp_irq", 32'(irq), 32'd1);
    check_eq("ackexp_ovf", 32'(ovf), 32'd0);
    idle(4, 1'b0);

    // Start with zero count, then restart from EXPIRED.
    async_reset(1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_zero_running", 32'(running), 32'd0);
    drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(5);
    check_eq("exp_running", 32'(running), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("restart_count", 32'(count), 32'd5);
    check_eq("restart_running", 32'(running), 32'd1);

    // Reset in the middle of a countdown.
    drive(1'b1, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    edges(2);
    check_eq("mid_count", 32'(count), 32'd4);
    async_reset(1'b0);

    // Randomized traffic: at most one of load/start/stop per cycle.
    cur_in = 1'b0;
    hold   = 3;
    for (int i = 0; i < 4000; i++) begin
      logic ld, st, sp, ack;
      logic [CntW-1:0] lv;
      if (hold == 0) begin
        cur_in = ~cur_in;
        hold   = int'($urandom_range(1, 5));
      end
      hold--;
      cmd = int'($urandom_range(0, 99));
      ld  = (cmd < 3);
      st  = (cmd >= 3 && cmd < 13);
      sp  = (cmd >= 13 && cmd < 16);
      ack = ($urandom_range(0, 29) == 0);
      lv  = CntW'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
      drive(ld, lv, st, sp, ack, cur_in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
